// File: rtl/sblk_act_feeder_if.sv
// Activation stream bundle: upstream valid/ready source plus the ACTBUF write strobe path.
// The master side is the feeder; the slave side is the DMA source and the controller.
interface sblk_act_feeder_if #(
    parameter int ACT_W = 64
) ();
    logic [ACT_W-1:0] src_data;
    logic             src_vld;
    logic             src_rdy;
    logic             actbuf_wr_req;
    logic             actbuf_wr_vld;
    logic [ACT_W-1:0] actbuf_wr_data;

    modport master (
        input  src_data,
        input  src_vld,
        input  actbuf_wr_req,
        output src_rdy,
        output actbuf_wr_vld,
        output actbuf_wr_data
    );

    modport slave (
        output src_data,
        output src_vld,
        output actbuf_wr_req,
        input  src_rdy,
        input  actbuf_wr_vld,
        input  actbuf_wr_data
    );
endinterface

// File: rtl/sblk_act_feeder.sv
// Streams exactly one ACTBUF tile (D1 x rows words) per controller request, with a
// registered write strobe and a guard state that ignores the controller's stale request.
module sblk_act_feeder #(
    parameter int D1        = 8,
    parameter int ADDRM_LEN = 8,
    parameter int ACT_W     = 64,
    parameter int TCNT_W    = 16
) (
    input  logic                 clk_l,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [ADDRM_LEN-1:0] cfg_addrm_max,
    sblk_act_feeder_if.master    bus,
    output logic                 feed_busy,
    output logic                 tile_done,
    output logic [TCNT_W-1:0]    tile_cnt
);
    localparam int TPE_W = (D1 > 1) ? $clog2(D1) : 1;
    localparam logic [TPE_W-1:0] TPE_LAST = TPE_W'(D1 - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_STREAM   = 2'd1;
    localparam logic [1:0] ST_WAIT_REQ = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [ADDRM_LEN-1:0] addrm_reg;
    logic [ADDRM_LEN-1:0] row_max_reg;
    logic [TPE_W-1:0]     tpe_cnt_reg;
    logic [ADDRM_LEN-1:0] row_cnt_reg;
    logic                 wr_vld_reg;
    logic [ACT_W-1:0]     wr_data_reg;
    logic                 tile_done_reg;
    logic [TCNT_W-1:0]    tile_cnt_reg;

    logic streaming;
    logic beat;
    logic last_beat;

    assign streaming = (state_reg == ST_STREAM);
    assign beat      = bus.src_vld & streaming;
    // Row compare wraps modulo 2^ADDRM_LEN, so a row count of 0 means a full 2^ADDRM_LEN rows.
    assign last_beat = (tpe_cnt_reg == TPE_LAST) &&
                       (row_cnt_reg == (row_max_reg - ADDRM_LEN'(1)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (bus.actbuf_wr_req) state_next = ST_STREAM;
            ST_STREAM:   if (beat && last_beat) state_next = ST_WAIT_REQ;
            ST_WAIT_REQ: if (!bus.actbuf_wr_req) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addrm_reg     <= '0;
            row_max_reg   <= '0;
            tpe_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            wr_vld_reg    <= 1'b0;
            wr_data_reg   <= '0;
            tile_done_reg <= 1'b0;
            tile_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wr_vld_reg    <= beat;
            tile_done_reg <= beat && last_beat;
            if (cfg_en)
                addrm_reg <= cfg_addrm_max;
            // The row count is frozen per tile so a config write mid-tile only affects the next one.
            if (state_reg == ST_IDLE && bus.actbuf_wr_req) begin
                row_max_reg <= addrm_reg;
                tpe_cnt_reg <= '0;
                row_cnt_reg <= '0;
            end
            if (beat) begin
                wr_data_reg <= bus.src_data;
                if (tpe_cnt_reg == TPE_LAST) begin
                    tpe_cnt_reg <= '0;
                    row_cnt_reg <= row_cnt_reg + ADDRM_LEN'(1);
                end else begin
                    tpe_cnt_reg <= tpe_cnt_reg + TPE_W'(1);
                end
                if (last_beat)
                    tile_cnt_reg <= tile_cnt_reg + TCNT_W'(1);
            end
        end
    end

    assign bus.src_rdy        = streaming;
    assign bus.actbuf_wr_vld  = wr_vld_reg;
    assign bus.actbuf_wr_data = wr_data_reg;
    assign feed_busy          = (state_reg != ST_IDLE);
    assign tile_done          = tile_done_reg;
    assign tile_cnt           = tile_cnt_reg;
endmodule

// File: tb/tb_sblk_act_feeder.sv
// Randomized bench for sblk_act_feeder: a beat-budget model predicts every strobe, word,
// tile_done pulse and tile count, while an emulated controller drives the request.
module tb_sblk_act_feeder;
    localparam int D1        = 8;
    localparam int ADDRM_LEN = 8;
    localparam int ACT_W     = 64;
    localparam int TCNT_W    = 16;

    logic                 clk_l = 1'b0;
    logic                 rst;
    logic                 cfg_en;
    logic [ADDRM_LEN-1:0] cfg_addrm_max;
    logic                 feed_busy;
    logic                 tile_done;
    logic [TCNT_W-1:0]    tile_cnt;

    sblk_act_feeder_if #(.ACT_W(ACT_W)) bus ();

    sblk_act_feeder #(
        .D1(D1), .ADDRM_LEN(ADDRM_LEN), .ACT_W(ACT_W), .TCNT_W(TCNT_W)
    ) dut (
        .clk_l(clk_l),
        .rst(rst),
        .cfg_en(cfg_en),
        .cfg_addrm_max(cfg_addrm_max),
        .bus(bus),
        .feed_busy(feed_busy),
        .tile_done(tile_done),
        .tile_cnt(tile_cnt)
    );

    always #5 clk_l = ~clk_l;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = no tile, 1 = tile in progress, 2 = tile sent, waiting for request release.
    int               m_phase = 0;
    int               m_left  = 0;
    int               m_len   = 0;
    int               m_beats = 0;
    int               m_cfg   = 0;
    int               m_tiles = 0;
    logic             exp_vld  = 1'b0;
    logic [ACT_W-1:0] exp_data = '0;
    logic             exp_done = 1'b0;
    int               obs_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs are already set; check pre-edge outputs, predict, clock, check post-edge outputs.
    task automatic step();
        logic             acc;
        logic             nv;
        logic             ndone;
        logic [ACT_W-1:0] nd;
        check("src_rdy", 64'(bus.src_rdy), 64'(m_phase == 1));
        check("feed_busy", 64'(feed_busy), 64'(m_phase != 0));
        acc = (m_phase == 1) && bus.src_vld;
        if (rst) begin
            m_phase = 0; m_cfg = 0; m_tiles = 0;
            nv = 1'b0; ndone = 1'b0; nd = '0;
        end else begin
            nv = acc; ndone = 1'b0; nd = exp_data;
            if (acc) begin
                nd = bus.src_data;
                m_left--;
                m_beats++;
                if (m_left == 0) begin
                    ndone = 1'b1;
                    m_tiles++;
                    m_phase = 2;
                end
            end else if (m_phase == 0 && bus.actbuf_wr_req) begin
                m_phase = 1;
                m_len   = D1 * ((m_cfg == 0) ? (1 << ADDRM_LEN) : m_cfg);
                m_left  = m_len;
                m_beats = 0;
            end else if (m_phase == 2 && !bus.actbuf_wr_req) begin
                m_phase = 0;
            end
            if (cfg_en) m_cfg = int'(cfg_addrm_max);
        end
        exp_vld = nv; exp_data = nd; exp_done = ndone;
        @(posedge clk_l);
        @(negedge clk_l);
        check("wr_vld", 64'(bus.actbuf_wr_vld), 64'(exp_vld));
        check("wr_data", 64'(bus.actbuf_wr_data), 64'(exp_data));
        check("tile_done", 64'(tile_done), 64'(exp_done));
        check("tile_cnt", 64'(tile_cnt), 64'(m_tiles % (1 << TCNT_W)));
        if (bus.actbuf_wr_vld === 1'b1) obs_cnt++;
    endtask

    task automatic idle_step(input logic do_cfg, input int cfg_v);
        bus.actbuf_wr_req = 1'b0;
        bus.src_vld  = $urandom_range(1);
        bus.src_data = {$urandom, $urandom};
        cfg_en        = do_cfg;
        cfg_addrm_max = ADDRM_LEN'(cfg_v);
        step();
        cfg_en = 1'b0;
    endtask

    // Controller emulation: raise req, run until the tile ends (or reset hits), keep req high
    // for `hold` cycles after tile_done (the stale request), then drop it for one cycle.
    task automatic drive_tile(input int pct, input int hold, input int cfg_beat,
                              input int cfg_v, input int rst_beat);
        int cyc;
        bit done;
        bit was_rst;
        cyc = 0; done = 0; was_rst = 0;
        obs_cnt = 0;
        bus.actbuf_wr_req = 1'b1;
        while (!done && cyc < 5000) begin
            bus.src_vld   = ($urandom_range(99) < pct);
            bus.src_data  = {$urandom, $urandom};
            cfg_en        = (m_phase == 1 && m_beats == cfg_beat);
            cfg_addrm_max = ADDRM_LEN'(cfg_v);
            rst           = (m_phase == 1 && m_beats == rst_beat);
            was_rst       = rst;
            step();
            cyc++;
            if (was_rst || exp_done) done = 1;
        end
        rst = 1'b0;
        cfg_en = 1'b0;
        if (!done) begin
            check("tile_timeout", 64'(0), 64'(1));
            return;
        end
        if (was_rst) begin
            $display("tile aborted by reset after %0d strobes", obs_cnt);
            return;
        end
        check("tile_len", 64'(obs_cnt), 64'(m_len));
        $display("tile %0d: %0d strobes in %0d cycles, src_vld %0d%%", m_tiles, obs_cnt, cyc, pct);
        for (int h = 0; h < hold; h++) begin
            bus.src_vld  = $urandom_range(1);
            bus.src_data = {$urandom, $urandom};
            step();
        end
        check("no_extra_beat", 64'(obs_cnt), 64'(m_len));
        bus.actbuf_wr_req = 1'b0;
        bus.src_vld  = 1'b1;
        bus.src_data = {$urandom, $urandom};
        step();
    endtask

    initial begin
        rst = 1'b1;
        cfg_en = 1'b0;
        cfg_addrm_max = '0;
        bus.src_vld = 1'b0;
        bus.src_data = '0;
        bus.actbuf_wr_req = 1'b0;
        @(posedge clk_l);
        @(posedge clk_l);
        @(negedge clk_l);
        step();
        rst = 1'b0;
        idle_step(1'b0, 0);

        idle_step(1'b1, 4);
        drive_tile(100, 1, -1, 0, -1);   // basic 32-beat tile, back-to-back
        drive_tile(50, 1, -1, 0, -1);    // source gaps, single-cycle req drop
        drive_tile(70, 1, 5, 2, -1);     // config write mid-tile: still 32 beats
        drive_tile(100, 10, -1, 0, -1);  // 16 beats, request held long after the end
        idle_step(1'b1, 0);
        drive_tile(100, 1, -1, 0, -1);   // 2^ADDRM_LEN rows: 2048 beats
        idle_step(1'b1, 4);
        drive_tile(100, 1, -1, 0, 10);   // reset at beat 10
        idle_step(1'b0, 0);
        idle_step(1'b1, 3);
        drive_tile(60, 2, -1, 0, -1);    // 24 beats after reset, tile_cnt restarts at 1
        check("final_tile_cnt", 64'(tile_cnt), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
